pll_reconfig_ctrl: RTL and testbench
====================================

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 8: number of entries in the internal reconfiguration table.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles to wait for PLL lock after START.
REQ-003 SHALL have parameter LOCK_HOLDOFF, default 16: cycles ignored after START before lock is sampled.
REQ-004 SHALL have port refclk, in, 1: single clock, PLL management clock domain.
REQ-005 SHALL have port rst_n, in, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_we, in, 1: writes one table entry.
REQ-007 SHALL have port cfg_idx, in, $clog2(NUM_WORDS): table entry index.
REQ-008 SHALL have port cfg_addr, in, 6: reconfiguration register address for the entry.
REQ-009 SHALL have port cfg_data, in, 32: register data for the entry.
REQ-010 SHALL have port cfg_count, in, $clog2(NUM_WORDS)+1: number of entries to apply, sampled on start.
REQ-011 SHALL have port start, in, 1: single-cycle request to run a reconfiguration.
REQ-012 SHALL have port busy, out, 1: high while the sequence runs.
REQ-013 SHALL have port done, out, 1: one-cycle pulse at sequence end.
REQ-014 SHALL have port error, out, 1: lock timeout flag, held until the next accepted start.
REQ-015 SHALL have Avalon-MM master ports mgmt_address (out, 6), mgmt_writedata (out, 32), mgmt_write (out, 1) and mgmt_waitrequest (in, 1).
REQ-016 SHALL have port pll_locked, in, 1: PLL locked signal, asynchronous to refclk.

Function
REQ-017 SHALL use FSM states IDLE, MODE, WRITE, START, LOCK_WAIT, DONE.
REQ-018 SHALL, in IDLE, accept start only when busy=0; start while busy SHALL be ignored.
REQ-019 SHALL ignore cfg_we while busy=1; in IDLE, cfg_we SHALL write table[cfg_idx] in the same cycle.
REQ-020 SHALL clamp cfg_count > NUM_WORDS to NUM_WORDS.
REQ-021 SHALL, on start with cfg_count=0, pulse done one cycle later with no bus activity and error cleared.
REQ-022 SHALL, on start with cfg_count≥1, enter MODE the next cycle, drive mgmt_write=1, address 0 and data 0 (waitrequest mode), and set busy=1.
REQ-023 SHALL complete each bus write in the cycle where mgmt_write=1 and mgmt_waitrequest=0, holding address, data and write stable while waitrequest=1.
REQ-024 SHALL, in WRITE, issue table entries 0..count-1 in order, back-to-back, with no idle cycle between completed writes.
REQ-025 SHALL, in START, write address 2 with data 0; waitrequest SHALL stretch this write until the PLL finishes.
REQ-026 SHALL, in LOCK_WAIT, count cycles from 0, ignore lock for the first LOCK_HOLDOFF cycles, and then go to DONE on the first synchronized pll_locked=1.
REQ-027 SHALL, when the count reaches LOCK_TIMEOUT without lock, set error=1 and go to DONE.
REQ-028 SHALL, in DONE, pulse done for one cycle, clear busy and return to IDLE.
REQ-029 SHALL synchronize pll_locked through 2 flops before use, giving 2 cycles of latency.
REQ-030 SHALL hold mgmt_write=0 outside MODE, WRITE and START.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE, busy=0, done=0, error=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0 and the synchronizer to 0.
REQ-032 SHALL, on reset mid-transaction, drop mgmt_write immediately, without waiting for waitrequest.
REQ-033 SHALL leave table contents undefined after reset; the table is not reset.

Structure
REQ-034 SHALL place the state enum, register address constants (MODE=0, START=2) and address/data widths in package pll_reconfig_pkg.
REQ-035 SHALL implement the lock synchronizer as sub-module pll_lock_sync (2-flop, async active-low reset).

Verification
REQ-036 SHALL cover: load 3 entries {(4,0x00000505),(5,0x00000303),(6,0x00010000)}, count=3, start, waitrequest=0, lock at cycle 20 -> writes (0,0),(4,..),(5,..),(6,..),(2,0) on consecutive cycles 1-5, then done pulse, error=0.
REQ-037 SHALL cover: waitrequest held high 7 cycles during entry 1 -> address and data stable all 7 cycles, and entry 2 issued the cycle after waitrequest falls.
REQ-038 SHALL cover: count=0 -> done at cycle 1 and mgmt_write never asserted.
REQ-039 SHALL cover: LOCK_TIMEOUT=100 with pll_locked stuck 0 -> error=1 and done exactly 100 cycles after the START write completes; the next start clears error.
REQ-040 SHALL cover: rst_n low during the START write -> mgmt_write=0 and busy=0 in the same cycle; a start after release runs normally.
REQ-041 SHALL cover: cfg_we and start asserted while busy -> table unchanged and no second sequence runs.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration controller.
package pll_reconfig_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    // Management register map of the reconfiguration block.
    localparam logic [ADDR_W-1:0] REG_MODE  = 6'd0;
    localparam logic [ADDR_W-1:0] REG_START = 6'd2;

    // MODE=0 selects waitrequest mode: the START write stalls until the PLL is done.
    localparam logic [DATA_W-1:0] MODE_WAITREQ = '0;
    localparam logic [DATA_W-1:0] START_GO     = '0;

    typedef enum logic [2:0] {
        StIdle,
        StMode,
        StWrite,
        StStart,
        StLockWait,
        StDone
    } state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into refclk.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: replays a table of register writes over an Avalon-MM
// management port, triggers the reconfiguration and waits for the PLL to relock.
module pll_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned NUM_WORDS    = 8,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_HOLDOFF = 16
) (
    input  logic                         refclk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_WORDS)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]            cfg_addr,
    input  logic [DATA_W-1:0]            cfg_data,
    input  logic [$clog2(NUM_WORDS):0]   cfg_count,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [ADDR_W-1:0]            mgmt_address,
    output logic [DATA_W-1:0]            mgmt_writedata,
    output logic                         mgmt_write,
    input  logic                         mgmt_waitrequest,
    input  logic                         pll_locked
);

    localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WCNT_W = $clog2(LOCK_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              error_q, error_d;

    logic [ADDR_W-1:0] tbl_addr_q [NUM_WORDS];
    logic [DATA_W-1:0] tbl_data_q [NUM_WORDS];
    logic              tbl_we;
    logic [CNT_W-1:0]  count_clamped;
    logic              lock_sync;
    logic [31:0]       wait_elapsed;
    logic              last_entry;

    pll_lock_sync u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .async_i(pll_locked),
        .sync_o (lock_sync)
    );

    // The table is plain storage with no reset; it only accepts writes while idle.
    assign tbl_we = cfg_we && (state_q == StIdle) && (32'(cfg_idx) < NUM_WORDS);

    always_ff @(posedge refclk) begin
        if (tbl_we) begin
            tbl_addr_q[cfg_idx] <= cfg_addr;
            tbl_data_q[cfg_idx] <= cfg_data;
        end
    end

    assign count_clamped = (32'(cfg_count) > NUM_WORDS) ? CNT_W'(NUM_WORDS) : cfg_count;
    assign wait_elapsed  = 32'(wait_cnt_q);
    assign last_entry    = (idx_q == (count_q - CNT_W'(1)));
    assign error         = error_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
        end
    end

    // Bus outputs decode from registered state only, so an asynchronous reset
    // removes mgmt_write at once regardless of waitrequest.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        count_d        = count_q;
        wait_cnt_d     = wait_cnt_q;
        error_d        = error_q;
        busy           = 1'b0;
        done           = 1'b0;
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    error_d    = 1'b0;
                    idx_d      = '0;
                    wait_cnt_d = '0;
                    count_d    = count_clamped;
                    state_d    = (count_clamped == '0) ? StDone : StMode;
                end
            end

            StMode: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = REG_MODE;
                mgmt_writedata = MODE_WAITREQ;
                if (!mgmt_waitrequest) begin
                    state_d = StWrite;
                end
            end

            StWrite: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = tbl_addr_q[idx_q[IDX_W-1:0]];
                mgmt_writedata = tbl_data_q[idx_q[IDX_W-1:0]];
                if (!mgmt_waitrequest) begin
                    if (last_entry) begin
                        state_d = StStart;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end

            StStart: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = REG_START;
                mgmt_writedata = START_GO;
                if (!mgmt_waitrequest) begin
                    // The completing edge counts as the first elapsed cycle.
                    wait_cnt_d = WCNT_W'(1);
                    state_d    = StLockWait;
                end
            end

            StLockWait: begin
                busy = 1'b1;
                if (lock_sync && (wait_elapsed > LOCK_HOLDOFF)) begin
                    state_d = StDone;
                end else if ((wait_elapsed + 32'd1) >= LOCK_TIMEOUT) begin
                    error_d = 1'b1;
                    state_d = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a transaction-level reference model.
module tb_pll_reconfig_ctrl;

    localparam int unsigned NW   = 8;
    localparam int unsigned TMO  = 100;
    localparam int unsigned HOLD = 16;

    logic        refclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [5:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic [3:0]  cfg_count = '0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pll_reconfig_ctrl #(
        .NUM_WORDS   (NW),
        .LOCK_TIMEOUT(TMO),
        .LOCK_HOLDOFF(HOLD)
    ) dut (
        .refclk          (refclk),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .cfg_idx         (cfg_idx),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .cfg_count       (cfg_count),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .mgmt_address    (mgmt_address),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_write      (mgmt_write),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked      (pll_locked)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: actual 0x%0h required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a start turns into a queue of expected bus writes; after the
    // last write completes, the model counts elapsed cycles for holdoff and timeout.
    typedef enum int {MIdle, MBus, MWait, MDone} mphase_e;
    mphase_e     m_phase = MIdle;
    logic [5:0]  m_qa[$];
    logic [31:0] m_qd[$];
    logic [5:0]  m_ta[NW];
    logic [31:0] m_td[NW];
    int          m_k = 0;
    logic        m_err = 1'b0;
    logic        m_lk1 = 1'b0;
    logic        m_lk2 = 1'b0;

    always @(negedge refclk) begin
        logic        exp_wr;
        logic [5:0]  exp_a;
        logic [31:0] exp_d;
        int          n;
        if (!rst_n) begin
            m_phase = MIdle;
            m_qa.delete();
            m_qd.delete();
            m_err = 1'b0;
            m_lk1 = 1'b0;
            m_lk2 = 1'b0;
            m_k = 0;
        end
        exp_wr = (m_phase == MBus);
        exp_a  = exp_wr ? m_qa[0] : 6'd0;
        exp_d  = exp_wr ? m_qd[0] : 32'd0;
        chk("mgmt_write", mgmt_write, exp_wr);
        chk("mgmt_address", mgmt_address, exp_a);
        chk("mgmt_writedata", mgmt_writedata, exp_d);
        chk("busy", busy, (m_phase == MBus) || (m_phase == MWait));
        chk("done", done, m_phase == MDone);
        chk("error", error, m_err);
        if (rst_n) begin
            case (m_phase)
                MIdle: begin
                    if (cfg_we) begin
                        m_ta[cfg_idx] = cfg_addr;
                        m_td[cfg_idx] = cfg_data;
                    end
                    if (start) begin
                        n = (cfg_count > 4'(NW)) ? NW : int'(cfg_count);
                        m_err = 1'b0;
                        if (n == 0) begin
                            m_phase = MDone;
                        end else begin
                            m_qa.push_back(6'd0);
                            m_qd.push_back(32'd0);
                            for (int i = 0; i < n; i++) begin
                                m_qa.push_back(m_ta[i]);
                                m_qd.push_back(m_td[i]);
                            end
                            m_qa.push_back(6'd2);
                            m_qd.push_back(32'd0);
                            m_phase = MBus;
                        end
                    end
                end
                MBus: begin
                    if (!mgmt_waitrequest) begin
                        void'(m_qa.pop_front());
                        void'(m_qd.pop_front());
                        if (m_qa.size() == 0) begin
                            m_phase = MWait;
                            m_k = 1;
                        end
                    end
                end
                MWait: begin
                    if (m_lk2 && (m_k > int'(HOLD))) begin
                        m_phase = MDone;
                    end else if (m_k == int'(TMO) - 1) begin
                        m_err = 1'b1;
                        m_phase = MDone;
                    end else begin
                        m_k++;
                    end
                end
                default: m_phase = MIdle;
            endcase
            m_lk2 = m_lk1;
            m_lk1 = pll_locked;
        end
    end

    // Bus-write log and stall statistics for the literal checks.
    logic [5:0]  wl_addr[$];
    logic [31:0] wl_data[$];
    int          wl_cyc[$];
    int          done_cyc = -1;
    int          stall_total = 0;
    int          stall_match = 0;

    always @(negedge refclk) begin
        if (rst_n) begin
            if (mgmt_write && !mgmt_waitrequest) begin
                wl_addr.push_back(mgmt_address);
                wl_data.push_back(mgmt_writedata);
                wl_cyc.push_back(cyc);
            end
            if (mgmt_write && mgmt_waitrequest) begin
                stall_total++;
                if (mgmt_address == 6'd5 && mgmt_writedata == 32'h0000_0303) stall_match++;
            end
            if (done) done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic run(input logic [3:0] count, output int t0);
        cfg_count = count;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge refclk);
            if (done) break;
        end
        checks++;
        if (n == budget) begin
            errors++;
            $display("FAIL wait_done %s: no done pulse within %0d cycles", name, budget);
        end
        tick();
    endtask

    initial begin
        int t0;
        int b;
        int s0;
        int s1;
        logic [5:0]  la[3];
        logic [31:0] ld[3];
        la[0] = 6'd4; ld[0] = 32'h0000_0505;
        la[1] = 6'd5; ld[1] = 32'h0000_0303;
        la[2] = 6'd6; ld[2] = 32'h0001_0000;

        #1 rst_n = 1'b0;
        #2;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset error", error, 1'b0);
        chk("reset mgmt_write", mgmt_write, 1'b0);
        chk("reset mgmt_address", mgmt_address, 6'd0);
        chk("reset mgmt_writedata", mgmt_writedata, 32'd0);
        repeat (3) @(posedge refclk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < int'(NW); i++) begin
            cfg_we = 1'b1;
            cfg_idx = 3'(i);
            cfg_addr = (i < 3) ? la[i] : 6'(8 + i);
            cfg_data = (i < 3) ? ld[i] : (32'hA500_0000 | 32'(i));
            tick();
        end
        cfg_we = 1'b0;

        // Three entries, no stalls, lock rises at cycle 20.
        b = wl_addr.size();
        run(4'd3, t0);
        while (cyc < t0 + 20) tick();
        pll_locked = 1'b1;
        wait_done(100, "basic");
        chk("basic write count", 32'(wl_addr.size() - b), 32'd5);
        chk("basic w0 addr", wl_addr[b], 6'd0);
        chk("basic w0 data", wl_data[b], 32'd0);
        chk("basic w1 addr", wl_addr[b+1], 6'd4);
        chk("basic w1 data", wl_data[b+1], 32'h0000_0505);
        chk("basic w2 addr", wl_addr[b+2], 6'd5);
        chk("basic w2 data", wl_data[b+2], 32'h0000_0303);
        chk("basic w3 addr", wl_addr[b+3], 6'd6);
        chk("basic w3 data", wl_data[b+3], 32'h0001_0000);
        chk("basic w4 addr", wl_addr[b+4], 6'd2);
        chk("basic w4 data", wl_data[b+4], 32'd0);
        for (int i = 0; i < 5; i++) chk("basic write cycle", 32'(wl_cyc[b+i] - t0), 32'(i + 1));
        chk("basic done cycle", 32'(done_cyc - t0), 32'd23);
        chk("basic error", error, 1'b0);
        pll_locked = 1'b0;
        repeat (4) tick();

        // Waitrequest stretches entry 1 for seven cycles.
        b = wl_addr.size();
        s0 = stall_total;
        s1 = stall_match;
        pll_locked = 1'b1;
        run(4'd3, t0);
        while (cyc < t0 + 3) tick();
        mgmt_waitrequest = 1'b1;
        while (cyc < t0 + 10) tick();
        mgmt_waitrequest = 1'b0;
        wait_done(100, "stall");
        chk("stall cycles", 32'(stall_total - s0), 32'd7);
        chk("stall stable", 32'(stall_match - s1), 32'd7);
        chk("stall entry1 cycle", 32'(wl_cyc[b+2] - t0), 32'd10);
        chk("stall entry2 addr", wl_addr[b+3], 6'd6);
        chk("stall entry2 cycle", 32'(wl_cyc[b+3] - t0), 32'd11);
        chk("stall done cycle", 32'(done_cyc - t0), 32'd30);
        pll_locked = 1'b0;
        repeat (4) tick();

        // Zero-length sequence.
        b = wl_addr.size();
        run(4'd0, t0);
        wait_done(10, "count0");
        chk("count0 done cycle", 32'(done_cyc - t0), 32'd1);
        chk("count0 no writes", 32'(wl_addr.size() - b), 32'd0);

        // Lock never arrives.
        b = wl_addr.size();
        run(4'd1, t0);
        wait_done(300, "timeout");
        chk("timeout write count", 32'(wl_addr.size() - b), 32'd3);
        chk("timeout after start", 32'(done_cyc - wl_cyc[b+2]), 32'd100);
        chk("timeout done cycle", 32'(done_cyc - t0), 32'd103);
        chk("timeout error set", error, 1'b1);
        run(4'd0, t0);
        chk("timeout error cleared", error, 1'b0);
        wait_done(10, "clear");

        // Reset while the START write is stalled.
        run(4'd2, t0);
        while (cyc < t0 + 4) tick();
        mgmt_waitrequest = 1'b1;
        while (cyc < t0 + 6) tick();
        chk("pre-reset mgmt_write", mgmt_write, 1'b1);
        chk("pre-reset address", mgmt_address, 6'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid reset mgmt_write", mgmt_write, 1'b0);
        chk("mid reset busy", busy, 1'b0);
        tick();
        mgmt_waitrequest = 1'b0;
        rst_n = 1'b1;
        tick();
        b = wl_addr.size();
        pll_locked = 1'b1;
        run(4'd3, t0);
        wait_done(100, "post-reset");
        chk("post-reset write count", 32'(wl_addr.size() - b), 32'd5);
        chk("post-reset entry0", wl_addr[b+1], 6'd4);
        chk("post-reset error", error, 1'b0);

        // Table write and start while busy are ignored.
        b = wl_addr.size();
        run(4'd2, t0);
        tick();
        cfg_we = 1'b1;
        cfg_idx = 3'd0;
        cfg_addr = 6'd9;
        cfg_data = 32'hDEAD_BEEF;
        cfg_count = 4'd5;
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        start = 1'b0;
        wait_done(100, "busy-ignore");
        repeat (30) tick();
        chk("busy-ignore write count", 32'(wl_addr.size() - b), 32'd4);
        b = wl_addr.size();
        run(4'd1, t0);
        wait_done(100, "table-kept");
        chk("table kept addr", wl_addr[b+1], 6'd4);
        chk("table kept data", wl_data[b+1], 32'h0000_0505);

        // Count above NUM_WORDS is clamped.
        b = wl_addr.size();
        run(4'd15, t0);
        wait_done(200, "clamp");
        chk("clamp write count", 32'(wl_addr.size() - b), 32'd10);
        chk("clamp last entry addr", wl_addr[b+8], 6'd15);
        chk("clamp last entry data", wl_data[b+8], 32'hA500_0007);
        chk("clamp start addr", wl_addr[b+9], 6'd2);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
